rvh_l2_wb_responder: RTL and testbench
======================================

RVH_L2_WB_RESPONDER -- requirements
Module: rvh_l2_wb_responder

Interface
REQ-001 SHALL take parameter ADDR_W, default 40: AW byte address width.
REQ-002 SHALL take parameter DATA_W, default 64: W beat width. LINE_W = DATA_W*BURST_LEN.
REQ-003 SHALL take parameter BURST_LEN, default 4: beats per line. Power of 2, at most 256.
REQ-004 SHALL take parameter ID_W, default 8: transaction ID width.
REQ-005 SHALL take parameter AW_DEPTH, default 2: AW queue entries. OFF_W = log2(LINE_W/8).
REQ-006 Ports; clock and reset come first:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- awvalid/awready  in/out  1/1  AW handshake.
- awid  in  ID_W  write ID.
- awaddr  in  ADDR_W  line-aligned byte address.
- awlen  in  8  beats-1.
- awburst  in  2  burst type.
- wvalid/wready  in/out  1/1  W handshake.
- wdata  in  DATA_W  beat data.
- wlast  in  1  final beat marker.
- bvalid/bready  out/in  1/1  B handshake.
- bid  out  ID_W  response ID.
- bresp  out  2  00 OKAY, 10 SLVERR.
- mem_wr_valid/mem_wr_ready  out/in  1/1  backing-store line write.
- mem_wr_addr  out  ADDR_W-OFF_W  line address = awaddr[ADDR_W-1:OFF_W].
- mem_wr_data  out  LINE_W  assembled line; beat k occupies [k*DATA_W +: DATA_W].
- busy_o  out  1  FSM not IDLE or AW queue non-empty.

Function
REQ-007 SHALL drive awready = AW queue not full. On an AW handshake the queue SHALL push {awid, awaddr, awlen, awburst}. The push is independent of FSM state.
REQ-008 SHALL process one transaction at a time, in AW order, using FSM states IDLE, COLLECT, COMMIT, RESP.
REQ-009 IDLE: if the queue is non-empty, SHALL latch the head fields, clear beat_cnt and err, and enter COLLECT on the next edge. wready SHALL be 0 in IDLE.
- With an empty queue, wready is first asserted 2 cycles after the AW handshake cycle.
REQ-010 COLLECT: wready SHALL be 1. Each W handshake SHALL store wdata into line slot beat_cnt and increment beat_cnt (8-bit).
- Throughput is 1 beat per cycle with no bubbles.
REQ-011 SHALL set err if any of these holds:
- awburst != 2'b01;
- awlen != BURST_LEN-1;
- wlast differs from (beat_cnt == awlen) on any accepted beat.
REQ-012 On the handshake where beat_cnt == awlen, SHALL leave COLLECT. Exactly awlen+1 beats are consumed regardless of err.
- err = 0: enter COMMIT.
- err = 1: enter RESP with bresp = 10 and no memory write.
- Line slots for beats at or above BURST_LEN are discarded.
REQ-013 COMMIT: mem_wr_valid SHALL be 1, with mem_wr_addr and mem_wr_data held stable until mem_wr_ready.
- On handshake: enter RESP with bresp = 00.
- mem_wr_valid is first high in the cycle after the last W beat.
REQ-014 RESP: bvalid SHALL be 1, with bid = latched awid and bresp stable until bready.
- On handshake: pop the AW queue and return to IDLE.
- bvalid is first high in the cycle after the memory handshake, or after the last beat on error.
REQ-015 SHALL accept W beats only in COLLECT. W beats presented before their AW is accepted SHALL be stalled (wready = 0) and never dropped.
REQ-016 Simultaneous events:
- AW push and pop in the same cycle SHALL both take effect.
- When the queue is full, awready SHALL remain 0 until a pop. The pop-cycle awready is still 0, since awready is registered from occupancy.
REQ-017 Back-to-back transactions: with a queued AW, IDLE SHALL spend exactly 1 cycle before COLLECT.

Reset
REQ-018 While rst = 0, asynchronously:
- State = IDLE, queue emptied, beat_cnt = 0, err = 0.
- Outputs: awready = 0, wready = 0, bvalid = 0, mem_wr_valid = 0, bid = 0, bresp = 0, busy_o = 0.
- mem_wr_addr and mem_wr_data = 0.
REQ-019 After rst rises, SHALL drive awready = 1 from the first clock edge. A reset mid-burst SHALL discard the partial line and issue no memory write and no B response.

Verification
REQ-020 Single write: AW id=5, addr=0x1000, len=3, burst=01, then 4 beats 0xA..0xD with wlast on beat 3, mem_wr_ready=1, bready=1 -> mem_wr_addr = 0x1000>>5 = 0x80; mem_wr_data = {0xD,0xC,0xB,0xA}; B id=5, resp=00.
REQ-021 Back-pressure: mem_wr_ready low 5 cycles and bready low 3 cycles -> mem_wr_valid, data, bvalid and bid all held stable; exactly one memory write and one B.
REQ-022 Errors:
- awlen = 1 -> 2 beats consumed, no mem write, bresp = 10.
- wlast asserted on beat 1 of len=3 -> 4 beats consumed, bresp = 10.
- awburst = 00 -> bresp = 10.
REQ-023 Queue full: 3 AWs (ids 1,2,3) issued with W held off -> awready drops after 2 accepts; B order is 1, 2, 3; the third AW is accepted after the first B handshake.
REQ-024 Early W: wvalid asserted 4 cycles before the AW -> wready stays 0 until 2 cycles after the AW handshake; all beats land correctly.
REQ-025 Reset mid-burst: rst low after beat 2 of 4 -> all outputs 0 immediately; no mem_wr_valid or bvalid afterwards; a subsequent clean transaction completes OKAY.

Source files
------------

// File: rtl/rvh_l2_wb_responder_if.sv
// Write-side bus of the L2 writeback responder: AW/W/B channels plus the
// backing-store line-write port and the busy indication.
interface rvh_l2_wb_responder_if #(
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = 8
) ();
  localparam int LINE_W = DATA_W * BURST_LEN;
  localparam int OFF_W  = $clog2(LINE_W / 8);

  logic                     awvalid;
  logic                     awready;
  logic [ID_W-1:0]          awid;
  logic [ADDR_W-1:0]        awaddr;
  logic [7:0]               awlen;
  logic [1:0]               awburst;
  logic                     wvalid;
  logic                     wready;
  logic [DATA_W-1:0]        wdata;
  logic                     wlast;
  logic                     bvalid;
  logic                     bready;
  logic [ID_W-1:0]          bid;
  logic [1:0]               bresp;
  logic                     mem_wr_valid;
  logic                     mem_wr_ready;
  logic [ADDR_W-OFF_W-1:0]  mem_wr_addr;
  logic [LINE_W-1:0]        mem_wr_data;
  logic                     busy_o;

  modport master (
    output awvalid, awid, awaddr, awlen, awburst,
    output wvalid, wdata, wlast, bready, mem_wr_ready,
    input  awready, wready, bvalid, bid, bresp,
    input  mem_wr_valid, mem_wr_addr, mem_wr_data, busy_o
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awburst,
    input  wvalid, wdata, wlast, bready, mem_wr_ready,
    output awready, wready, bvalid, bid, bresp,
    output mem_wr_valid, mem_wr_addr, mem_wr_data, busy_o
  );
endinterface

// File: rtl/rvh_l2_wb_responder.sv
// L2 writeback responder: queues AW requests, assembles one full line from W
// beats, writes it to the backing store and returns a B response, in AW order.
module rvh_l2_wb_responder #(
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = 8,
  parameter int AW_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  rvh_l2_wb_responder_if.slave bus
);
  localparam int LINE_W = DATA_W * BURST_LEN;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int PTR_W  = (AW_DEPTH > 1) ? $clog2(AW_DEPTH) : 1;
  localparam int CNT_W  = $clog2(AW_DEPTH + 1);

  localparam logic [7:0]       LEN_FULL = 8'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(AW_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(AW_DEPTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [ID_W-1:0]   q_id    [AW_DEPTH];
  logic [ADDR_W-1:0] q_addr  [AW_DEPTH];
  logic [7:0]        q_len   [AW_DEPTH];
  logic [1:0]        q_burst [AW_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  q_cnt;
  logic [CNT_W-1:0]  q_cnt_nxt;
  logic              awready_q;
  logic              push;
  logic              pop;

  logic [1:0]        state;
  logic [ID_W-1:0]   cur_id;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_len;
  logic [7:0]        beat_cnt;
  logic              err;
  logic [1:0]        bresp_q;
  logic [LINE_W-1:0] line_q;

  logic              w_hs;
  logic              last_beat;
  logic              err_nxt;

  assign push      = bus.awvalid && awready_q;
  assign pop       = (state == S_RESP) && bus.bready;
  assign w_hs      = bus.wvalid && (state == S_COLLECT);
  assign last_beat = (beat_cnt == cur_len);
  assign err_nxt   = err || (bus.wlast != last_beat);

  always_comb begin
    q_cnt_nxt = q_cnt;
    if (push && !pop)
      q_cnt_nxt = q_cnt + 1'b1;
    else if (pop && !push)
      q_cnt_nxt = q_cnt - 1'b1;
  end

  // AW queue: head stays in place until its B handshake retires it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr]    <= bus.awid;
      q_addr[wr_ptr]  <= bus.awaddr;
      q_len[wr_ptr]   <= bus.awlen;
      q_burst[wr_ptr] <= bus.awburst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_cnt     <= '0;
      awready_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      q_cnt     <= q_cnt_nxt;
      awready_q <= (q_cnt_nxt != CNT_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cur_id   <= '0;
      cur_addr <= '0;
      cur_len  <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
      bresp_q  <= 2'b00;
      line_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (q_cnt != '0) begin
            cur_id   <= q_id[rd_ptr];
            cur_addr <= q_addr[rd_ptr];
            cur_len  <= q_len[rd_ptr];
            beat_cnt <= '0;
            // Header errors are known up front; beat errors accumulate later.
            err      <= (q_burst[rd_ptr] != 2'b01) || (q_len[rd_ptr] != LEN_FULL);
            state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_hs) begin
            for (int k = 0; k < BURST_LEN; k++)
              if (beat_cnt == 8'(k))
                line_q[k*DATA_W +: DATA_W] <= bus.wdata;
            beat_cnt <= beat_cnt + 1'b1;
            err      <= err_nxt;
            if (last_beat) begin
              if (err_nxt) begin
                bresp_q <= 2'b10;
                state   <= S_RESP;
              end else begin
                state   <= S_COMMIT;
              end
            end
          end
        end
        S_COMMIT: begin
          if (bus.mem_wr_ready) begin
            bresp_q <= 2'b00;
            state   <= S_RESP;
          end
        end
        default: begin
          if (bus.bready)
            state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.awready      = awready_q;
  assign bus.wready       = (state == S_COLLECT);
  assign bus.bvalid       = (state == S_RESP);
  assign bus.bid          = cur_id;
  assign bus.bresp        = bresp_q;
  assign bus.mem_wr_valid = (state == S_COMMIT);
  assign bus.mem_wr_addr  = cur_addr[ADDR_W-1:OFF_W];
  assign bus.mem_wr_data  = line_q;
  assign bus.busy_o       = (state != S_IDLE) || (q_cnt != '0);
endmodule

// File: tb/tb_rvh_l2_wb_responder.sv
// Bench for rvh_l2_wb_responder: scenario tasks drive AW/W traffic and push
// expected line writes and B responses; a negedge monitor pops and compares.
module tb_rvh_l2_wb_responder;
  localparam int ADDR_W    = 40;
  localparam int DATA_W    = 64;
  localparam int BURST_LEN = 4;
  localparam int ID_W      = 8;
  localparam int AW_DEPTH  = 2;
  localparam int LINE_W    = DATA_W * BURST_LEN;
  localparam int OFF_W     = $clog2(LINE_W / 8);
  localparam int MA_W      = ADDR_W - OFF_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_cnt = 0;
  int b_cnt = 0;

  logic [MA_W-1:0]   exp_addr_q [$];
  logic [LINE_W-1:0] exp_data_q [$];
  logic [ID_W-1:0]   exp_id_q   [$];
  logic [1:0]        exp_resp_q [$];
  int w_cyc [$];
  int mem_cyc [$];
  int b_cyc [$];

  logic [MA_W-1:0]   mon_addr;
  logic [LINE_W-1:0] mon_data;
  logic [ID_W-1:0]   mon_id;
  logic [1:0]        mon_resp;

  rvh_l2_wb_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .ID_W(ID_W)) bus ();

  rvh_l2_wb_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .ID_W(ID_W), .AW_DEPTH(AW_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end

  // Scoreboard monitor: every line write and B handshake is matched in order.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1) begin
      if (bus.mem_wr_valid && bus.mem_wr_ready) begin
        mem_cnt++;
        mem_cyc.push_back(cyc);
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: got write to %h, required no write", bus.mem_wr_addr);
        end else begin
          mon_addr = exp_addr_q.pop_front();
          mon_data = exp_data_q.pop_front();
          if (bus.mem_wr_addr !== mon_addr || bus.mem_wr_data !== mon_data) begin
            errors++;
            $display("FAIL mem_write: got addr %h data %h, required addr %h data %h",
                     bus.mem_wr_addr, bus.mem_wr_data, mon_addr, mon_data);
          end
        end
      end
      if (bus.bvalid && bus.bready) begin
        b_cnt++;
        b_cyc.push_back(cyc);
        checks++;
        if (exp_id_q.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got id %h resp %b, required no response", bus.bid, bus.bresp);
        end else begin
          mon_id   = exp_id_q.pop_front();
          mon_resp = exp_resp_q.pop_front();
          if (bus.bid !== mon_id || bus.bresp !== mon_resp) begin
            errors++;
            $display("FAIL b_resp: got id %h resp %b, required id %h resp %b",
                     bus.bid, bus.bresp, mon_id, mon_resp);
          end
        end
      end
    end
  end

  function automatic logic [LINE_W-1:0] line_of(input logic [DATA_W-1:0] base);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < BURST_LEN; k++)
      l[k*DATA_W +: DATA_W] = base + DATA_W'(k);
    return l;
  endfunction

  task automatic expect_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] base);
    logic [ADDR_W-1:0] sh;
    sh = addr >> OFF_W;
    exp_addr_q.push_back(sh[MA_W-1:0]);
    exp_data_q.push_back(line_of(base));
  endtask

  task automatic expect_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
    exp_id_q.push_back(id);
    exp_resp_q.push_back(resp);
  endtask

  // Drivers are entered just after a rising edge and return at the same phase.
  task automatic send_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst, output int acc);
    int n;
    n = 0;
    acc = -1;
    bus.awvalid = 1'b1;
    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awburst = burst;
    @(negedge clk);
    while (!bus.awready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.awready) begin
      acc = cyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL aw_timeout: got awready 0 for id %h, required accept", id);
    end
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DATA_W-1:0] base, input int nbeats, input logic [31:0] mask);
    int n;
    for (int k = 0; k < nbeats; k++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = base + DATA_W'(k);
      bus.wlast  = mask[k];
      n = 0;
      @(negedge clk);
      while (!bus.wready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (bus.wready) begin
        w_cyc.push_back(cyc);
      end else begin
        checks++;
        errors++;
        $display("FAIL w_timeout: got wready 0 on beat %0d, required accept", k);
      end
      @(posedge clk);
      #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic wait_b(input int target);
    int n;
    n = 0;
    while (b_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b_cnt < target) begin
      errors++;
      $display("FAIL b_timeout: got %0d responses, required %0d", b_cnt, target);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    w_cyc.delete();
    mem_cyc.delete();
    b_cyc.delete();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.mem_wr_valid, bus.busy_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got aw/w/b/mem/busy %b, required 00000",
               {bus.awready, bus.wready, bus.bvalid, bus.mem_wr_valid, bus.busy_o});
    end
    checks++;
    if ({bus.bid, bus.bresp} !== '0 || bus.mem_wr_addr !== '0 || bus.mem_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got bid %h bresp %b addr %h, required all zero",
               bus.bid, bus.bresp, bus.mem_wr_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.awready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_awready: got %b before first edge, required 0", bus.awready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.awready !== 1'b1 || bus.wready !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: got awready %b wready %b busy %b, required 1 0 0",
               bus.awready, bus.wready, bus.busy_o);
    end
  endtask

  task automatic test_single_write();
    int ca;
    int b0;
    b0 = b_cnt;
    clear_logs();
    exp_addr_q.push_back(35'h80);
    exp_data_q.push_back({64'hD, 64'hC, 64'hB, 64'hA});
    expect_b(8'd5, 2'b00);
    fork
      send_aw(8'd5, 40'h1000, 8'd3, 2'b01, ca);
      send_w(64'hA, 4, 32'h8);
    join
    wait_b(b0 + 1);
    checks++;
    if (w_cyc.size() != 4 || w_cyc[0] != ca + 2) begin
      errors++;
      $display("FAIL single_first_beat: got cycle %0d, required %0d", w_cyc[0], ca + 2);
    end
    checks++;
    if (mem_cyc.size() != 1 || mem_cyc[0] != w_cyc[3] + 1) begin
      errors++;
      $display("FAIL single_mem_latency: got cycle %0d, required %0d", mem_cyc[0], w_cyc[3] + 1);
    end
    checks++;
    if (b_cyc.size() != 1 || b_cyc[0] != mem_cyc[0] + 1) begin
      errors++;
      $display("FAIL single_b_latency: got cycle %0d, required %0d", b_cyc[0], mem_cyc[0] + 1);
    end
  endtask

  task automatic test_backpressure();
    int ca;
    int m0;
    int b0;
    int n;
    m0 = mem_cnt;
    b0 = b_cnt;
    clear_logs();
    bus.mem_wr_ready = 1'b0;
    bus.bready       = 1'b0;
    expect_write(40'h2040, 64'h100);
    expect_b(8'd9, 2'b00);
    fork
      send_aw(8'd9, 40'h2040, 8'd3, 2'b01, ca);
      send_w(64'h100, 4, 32'h8);
    join
    n = 0;
    @(negedge clk);
    while (!bus.mem_wr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.mem_wr_valid !== 1'b1 || bus.mem_wr_addr !== 35'h102 || bus.mem_wr_data !== line_of(64'h100)) begin
        errors++;
        $display("FAIL bp_mem_hold: got valid %b addr %h on stall %0d, required 1 102 stable",
                 bus.mem_wr_valid, bus.mem_wr_addr, i);
      end
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 bus.mem_wr_ready = 1'b1;
    @(posedge clk);
    #1 bus.mem_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_wr_valid !== 1'b0 || bus.bvalid !== 1'b1 || bus.bid !== 8'd9 || bus.bresp !== 2'b00) begin
        errors++;
        $display("FAIL bp_b_hold: got mem_valid %b bvalid %b bid %h bresp %b, required 0 1 09 00",
                 bus.mem_wr_valid, bus.bvalid, bus.bid, bus.bresp);
      end
    end
    @(posedge clk);
    #1 bus.bready = 1'b1;
    wait_b(b0 + 1);
    bus.mem_wr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (mem_cnt != m0 + 1 || b_cnt != b0 + 1) begin
      errors++;
      $display("FAIL bp_counts: got %0d writes %0d responses, required 1 1", mem_cnt - m0, b_cnt - b0);
    end
  endtask

  task automatic test_errors();
    logic [7:0]  lens   [3] = '{8'd1, 8'd3, 8'd3};
    logic [1:0]  bursts [3] = '{2'b01, 2'b01, 2'b00};
    int          nbeats [3] = '{2, 4, 4};
    logic [31:0] masks  [3] = '{32'h2, 32'hA, 32'h8};
    int ca;
    int m0;
    int b0;
    m0 = mem_cnt;
    for (int t = 0; t < 3; t++) begin
      b0 = b_cnt;
      clear_logs();
      expect_b(8'h21 + 8'(t), 2'b10);
      fork
        send_aw(8'h21 + 8'(t), 40'h3000, lens[t], bursts[t], ca);
        send_w(64'h300, nbeats[t], masks[t]);
      join
      wait_b(b0 + 1);
      checks++;
      if (w_cyc.size() != nbeats[t] || b_cyc.size() != 1 || b_cyc[0] != w_cyc[nbeats[t]-1] + 1) begin
        errors++;
        $display("FAIL err_case%0d_timing: got %0d beats, b at %0d, required %0d beats, b one cycle after last",
                 t, w_cyc.size(), b_cyc[0], nbeats[t]);
      end
      checks++;
      if (bus.busy_o !== 1'b0 || bus.wready !== 1'b0) begin
        errors++;
        $display("FAIL err_case%0d_idle: got busy %b wready %b, required 0 0", t, bus.busy_o, bus.wready);
      end
    end
    checks++;
    if (mem_cnt != m0) begin
      errors++;
      $display("FAIL err_no_mem: got %0d writes, required 0", mem_cnt - m0);
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    int b0;
    b0 = b_cnt;
    clear_logs();
    expect_write(40'h7000, 64'h700);
    expect_b(8'h41, 2'b00);
    expect_write(40'h7020, 64'h720);
    expect_b(8'h42, 2'b00);
    fork
      begin
        send_aw(8'h41, 40'h7000, 8'd3, 2'b01, c1);
        send_aw(8'h42, 40'h7020, 8'd3, 2'b01, c2);
      end
      begin
        send_w(64'h700, 4, 32'h8);
        send_w(64'h720, 4, 32'h8);
      end
    join
    wait_b(b0 + 2);
    checks++;
    if (w_cyc.size() != 8 || w_cyc[3] - w_cyc[0] != 3 || w_cyc[7] - w_cyc[4] != 3) begin
      errors++;
      $display("FAIL b2b_throughput: got spans %0d %0d, required 3 3", w_cyc[3] - w_cyc[0], w_cyc[7] - w_cyc[4]);
    end
    checks++;
    if (w_cyc[4] - w_cyc[3] != 4) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %0d cycles last-to-first beat, required 4", w_cyc[4] - w_cyc[3]);
    end
  endtask

  task automatic test_queue_full();
    int c1;
    int c2;
    int c3;
    int b0;
    b0 = b_cnt;
    clear_logs();
    for (int i = 1; i <= 3; i++) begin
      expect_write(40'h4000 + 40'((i - 1) * 32), 64'(i * 16));
      expect_b(8'(i), 2'b00);
    end
    fork
      begin
        send_aw(8'd1, 40'h4000, 8'd3, 2'b01, c1);
        send_aw(8'd2, 40'h4020, 8'd3, 2'b01, c2);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checks++;
          if (bus.awready !== 1'b0) begin
            errors++;
            $display("FAIL qfull_awready: got %b with 2 queued, required 0", bus.awready);
          end
        end
        @(posedge clk);
        #1;
        send_aw(8'd3, 40'h4040, 8'd3, 2'b01, c3);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        send_w(64'h10, 4, 32'h8);
        send_w(64'h20, 4, 32'h8);
        send_w(64'h30, 4, 32'h8);
      end
    join
    wait_b(b0 + 3);
    checks++;
    if (c2 != c1 + 1) begin
      errors++;
      $display("FAIL qfull_second_accept: got cycle %0d, required %0d", c2, c1 + 1);
    end
    checks++;
    if (b_cyc.size() != 3 || c3 != b_cyc[0] + 1) begin
      errors++;
      $display("FAIL qfull_third_accept: got cycle %0d, required %0d", c3, b_cyc[0] + 1);
    end
  endtask

  task automatic test_early_w();
    int ca;
    int b0;
    b0 = b_cnt;
    clear_logs();
    expect_write(40'h5000, 64'h500);
    expect_b(8'h77, 2'b00);
    ca = -1;
    fork
      send_w(64'h500, 4, 32'h8);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checks++;
          if (bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL early_w_stall: got wready %b before AW, required 0", bus.wready);
          end
        end
        @(posedge clk);
        #1;
        send_aw(8'h77, 40'h5000, 8'd3, 2'b01, ca);
      end
    join
    wait_b(b0 + 1);
    checks++;
    if (w_cyc.size() != 4 || w_cyc[0] != ca + 2) begin
      errors++;
      $display("FAIL early_w_first_beat: got cycle %0d, required %0d", w_cyc[0], ca + 2);
    end
  endtask

  task automatic test_reset_mid_burst();
    int ca;
    int m0;
    int b0;
    logic seen;
    m0 = mem_cnt;
    b0 = b_cnt;
    clear_logs();
    fork
      send_aw(8'h66, 40'h6000, 8'd3, 2'b01, ca);
      send_w(64'h600, 2, 32'h0);
    join
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.mem_wr_valid, bus.busy_o} !== 5'b0 ||
        {bus.bid, bus.bresp} !== '0 || bus.mem_wr_data !== '0) begin
      errors++;
      $display("FAIL midrst_async: got aw/w/b/mem/busy %b bid %h, required all zero",
               {bus.awready, bus.wready, bus.bvalid, bus.mem_wr_valid, bus.busy_o}, bus.bid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_wr_valid || bus.bvalid || bus.busy_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || mem_cnt != m0 || b_cnt != b0) begin
      errors++;
      $display("FAIL midrst_discard: got activity %b writes %0d responses %0d, required 0 0 0",
               seen, mem_cnt - m0, b_cnt - b0);
    end
    @(posedge clk);
    #1;
    expect_write(40'h6000, 64'h680);
    expect_b(8'h67, 2'b00);
    fork
      send_aw(8'h67, 40'h6000, 8'd3, 2'b01, ca);
      send_w(64'h680, 4, 32'h8);
    join
    wait_b(b0 + 1);
    checks++;
    if (mem_cnt != m0 + 1) begin
      errors++;
      $display("FAIL midrst_recover: got %0d writes, required 1", mem_cnt - m0);
    end
  endtask

  initial begin
    bus.awvalid      = 1'b0;
    bus.awid         = '0;
    bus.awaddr       = '0;
    bus.awlen        = '0;
    bus.awburst      = '0;
    bus.wvalid       = 1'b0;
    bus.wdata        = '0;
    bus.wlast        = 1'b0;
    bus.bready       = 1'b1;
    bus.mem_wr_ready = 1'b1;

    test_reset();
    test_single_write();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_queue_full();
    test_early_w();
    test_reset_mid_burst();

    checks++;
    if (exp_addr_q.size() != 0 || exp_id_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d writes %0d responses outstanding, required 0 0",
               exp_addr_q.size(), exp_id_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
